// File: rtl/frame_ram_arbiter.sv
// frame_ram_arbiter: shares the single-port frame RAM between VGA scan-out and the Sobel filter.
// Define FB_STALL_CNT_EN to add f_stall_cnt, a saturating count of filter-blocked cycles.
module frame_ram_arbiter #(
    parameter int IM_WIDTH  = 320,
    parameter int IM_LENGTH = 280,
    parameter int X_BEGIN   = 1,
    parameter int Y_BEGIN   = 1,
    parameter int ADDR_W    = 17,
    parameter int DATA_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_tick,
    input  logic              videoon,
    input  logic [10:0]       pixel_x,
    input  logic [10:0]       pixel_y,
    output logic [DATA_W-1:0] disp_dout,
    input  logic              f_req,
    input  logic              f_we,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic [DATA_W-1:0] f_wdata,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef FB_STALL_CNT_EN
    ,
    output logic [15:0]       f_stall_cnt
`endif
);
    typedef enum logic [2:0] {NONE, DISP, DISP_ZERO, FILT, FILT_ZERO} tag_t;

    localparam int IM_SIZE = IM_WIDTH * IM_LENGTH;

    tag_t              tag_n, tag1, tag2;
    logic              en_n, we_n, in_win, f_in_range;
    logic [ADDR_W-1:0] addr_n, disp_addr;
    logic [DATA_W-1:0] wdata_n;

    assign in_win = videoon
        && 32'(pixel_x) >= X_BEGIN && 32'(pixel_x) < X_BEGIN + IM_WIDTH
        && 32'(pixel_y) >= Y_BEGIN && 32'(pixel_y) < Y_BEGIN + IM_LENGTH;
    assign disp_addr = ADDR_W'(pixel_x) - ADDR_W'(X_BEGIN)
        + (ADDR_W'(pixel_y) - ADDR_W'(Y_BEGIN)) * ADDR_W'(IM_WIDTH);
    assign f_in_range = 32'(f_addr) < IM_SIZE;
    // A tick owns the slot even outside the window, so the filter never races the display
    assign f_gnt = rst_n && f_req && !pix_tick;

    always_comb begin
        en_n    = 1'b0;
        we_n    = 1'b0;
        addr_n  = '0;
        wdata_n = '0;
        tag_n   = NONE;
        if (pix_tick) begin
            en_n   = in_win;
            addr_n = in_win ? disp_addr : '0;
            tag_n  = in_win ? DISP : DISP_ZERO;
        end else if (f_req) begin
            en_n    = f_in_range;
            we_n    = f_we && f_in_range;
            addr_n  = f_addr;
            wdata_n = f_wdata;
            tag_n   = f_we ? NONE : (f_in_range ? FILT : FILT_ZERO);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            tag1      <= NONE;
            tag2      <= NONE;
            disp_dout <= '0;
            f_rvalid  <= 1'b0;
            f_rdata   <= '0;
        end else begin
            ram_en    <= en_n;
            ram_we    <= we_n;
            ram_addr  <= addr_n;
            ram_wdata <= wdata_n;
            tag1      <= tag_n;
            tag2      <= tag1;
            disp_dout <= tag2 == DISP ? ram_rdata : (tag2 == DISP_ZERO ? '0 : disp_dout);
            f_rvalid  <= tag2 == FILT || tag2 == FILT_ZERO;
            f_rdata   <= tag2 == FILT ? ram_rdata : (tag2 == FILT_ZERO ? '0 : f_rdata);
        end
    end

`ifdef FB_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            f_stall_cnt <= '0;
        else if (f_req && !f_gnt && f_stall_cnt != 16'hFFFF)
            f_stall_cnt <= f_stall_cnt + 16'd1;
    end
`endif
endmodule
